load_channel_responder: RTL and testbench

Memory-side responder for the load channel used by the instruction-cache fetch path. It accepts word load requests (request/address), queues them in an address FIFO, and issues them to a backend memory port with bounded outstanding reads. It returns read data in request order with a one-cycle valid strobe. On invalidate it discards queued requests and silently drops the responses of reads already in flight.

---
 rtl/load_channel_responder.sv | 137 +++++++++++++
 tb/tb_load_channel_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_channel_responder.sv
// Load-channel responder: queues word fetch addresses, issues them to a backend
// with bounded outstanding reads and returns data in order; invalidate flushes all.
module load_channel_responder #(
    parameter int FIFO_DEPTH      = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  request_i,
    input  logic [ADDR_WIDTH-1:0] address_i,
    input  logic                  invalidate_i,
    output logic [31:0]           data_o,
    output logic                  valid_o,
    output logic                  full_o,
    output logic                  busy_o,
    output logic                  overflow_o,
    output logic                  mem_request_o,
    output logic [ADDR_WIDTH-1:0] mem_address_o,
    input  logic                  mem_ready_i,
    input  logic [31:0]           mem_data_i,
    input  logic                  mem_valid_i
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [ADDR_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]        wr_ptr_q;
    logic [PTR_W:0]        rd_ptr_q;
    logic [PTR_W:0]        count;
    logic [PTR_W:0]        count_next;
    logic                  full_q;
    logic                  empty;
    logic [ADDR_WIDTH-1:0] head;
    logic [OUT_W-1:0]      outstanding_q;
    logic [OUT_W-1:0]      drop_count_q;
    logic                  overflow_q;
    logic                  valid_q;
    logic [31:0]           data_q;
    logic                  push;
    logic                  pop;
    logic                  resp_fire;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign count = wr_ptr_q - rd_ptr_q;
    assign head  = fifo_mem[rd_ptr_q[PTR_W-1:0]];

    assign pop  = !empty && (outstanding_q < OUT_W'(MAX_OUTSTANDING)) && mem_ready_i && !invalidate_i;
    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign push = request_i && !invalidate_i && (!full_q || pop);
    assign resp_fire = mem_valid_i && (drop_count_q == '0) && !invalidate_i;

    assign mem_request_o = pop;
    assign mem_address_o = pop ? {head[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign full_o        = full_q;
    assign overflow_o    = overflow_q;
    assign busy_o        = !empty || (outstanding_q != '0) || (drop_count_q != '0);
    assign valid_o       = valid_q && !invalidate_i;
    assign data_o        = data_q;

    always_comb begin
        count_next = count;
        if (invalidate_i) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + 1'b1;
                2'b01:   count_next = count - 1'b1;
                default: count_next = count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= address_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
        end else begin
            if (invalidate_i) begin
                rd_ptr_q <= wr_ptr_q;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            full_q <= (count_next == (PTR_W+1)'(FIFO_DEPTH));
        end
    end

    // outstanding counts every read in flight at the backend, zombies included;
    // drop_count is the subset whose data must be discarded.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            outstanding_q <= '0;
            drop_count_q  <= '0;
        end else begin
            case ({pop, mem_valid_i})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: outstanding_q <= outstanding_q;
            endcase
            if (invalidate_i) begin
                drop_count_q <= outstanding_q - OUT_W'(mem_valid_i);
            end else if (mem_valid_i && (drop_count_q != '0)) begin
                drop_count_q <= drop_count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            if (invalidate_i) begin
                overflow_q <= 1'b0;
            end else if (request_i && full_q && !pop) begin
                overflow_q <= 1'b1;
            end
            valid_q <= resp_fire;
            if (resp_fire) begin
                data_q <= mem_data_i;
            end
        end
    end

    a_no_orphan_response: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        mem_valid_i |-> (outstanding_q != '0));

endmodule

// File: tb/tb_load_channel_responder.sv
// Bench for load_channel_responder: table-driven burst, directed corner sequences
// and randomized traffic against a queue-based reference model.
module tb_load_channel_responder;
    localparam int DEPTH = 8;
    localparam int MAXO  = 4;
    localparam int AW    = 32;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          request_i;
    logic [AW-1:0] address_i;
    logic          invalidate_i;
    logic [31:0]   data_o;
    logic          valid_o;
    logic          full_o;
    logic          busy_o;
    logic          overflow_o;
    logic          mem_request_o;
    logic [AW-1:0] mem_address_o;
    logic          mem_ready_i;
    logic [31:0]   mem_data_i;
    logic          mem_valid_i;

    load_channel_responder #(
        .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .ADDR_WIDTH(AW)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .request_i(request_i), .address_i(address_i),
        .invalidate_i(invalidate_i), .data_o(data_o), .valid_o(valid_o), .full_o(full_o),
        .busy_o(busy_o), .overflow_o(overflow_o), .mem_request_o(mem_request_o),
        .mem_address_o(mem_address_o), .mem_ready_i(mem_ready_i), .mem_data_i(mem_data_i),
        .mem_valid_i(mem_valid_i)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct { logic [31:0] addr; bit live; } fly_t;
    typedef struct { logic [31:0] addr; int due; } be_t;

    logic [31:0] m_fifo[$];
    fly_t        m_fly[$];
    bit          m_pend;
    logic [31:0] m_data;
    bit          m_ovf;
    be_t         be_q[$];
    int          last_due = -1;
    int          be_lat   = 2;

    bit          obs_valid, obs_full, obs_busy, obs_ovf, obs_req, obs_mvalid;
    logic [31:0] obs_data, obs_addr;

    function automatic logic [31:0] fdata(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        m_fifo.delete();
        m_fly.delete();
        m_pend = 1'b0;
        m_data = '0;
        m_ovf  = 1'b0;
        be_q.delete();
        last_due = -1;
    endtask

    task automatic step(input bit req, input logic [31:0] addr, input bit inv, input bit rdy);
        bit          e_issue, e_full, e_busy, e_valid, acc, be_v;
        logic [31:0] e_addr, be_a;
        fly_t        fl;
        int          due;
        @(negedge clk_i);
        be_v = (be_q.size() > 0) && (be_q[0].due == cyc);
        be_a = '0;
        if (be_v) begin
            be_a = be_q[0].addr;
            void'(be_q.pop_front());
        end
        request_i    = req;
        address_i    = addr;
        invalidate_i = inv;
        mem_ready_i  = rdy;
        mem_valid_i  = be_v;
        mem_data_i   = be_v ? fdata(be_a) : $urandom();
        #1;
        e_full  = (m_fifo.size() == DEPTH);
        e_issue = (m_fifo.size() > 0) && (m_fly.size() < MAXO) && rdy && !inv;
        e_addr  = e_issue ? {m_fifo[0][31:2], 2'b00} : 32'h0;
        e_busy  = (m_fifo.size() > 0) || (m_fly.size() > 0);
        e_valid = m_pend && !inv;
        chk("valid_o", valid_o, e_valid);
        chk("data_o", data_o, m_data);
        chk("full_o", full_o, e_full);
        chk("busy_o", busy_o, e_busy);
        chk("overflow_o", overflow_o, m_ovf);
        chk("mem_request_o", mem_request_o, e_issue);
        chk("mem_address_o", mem_address_o, e_addr);
        obs_valid = valid_o; obs_data = data_o; obs_full = full_o; obs_busy = busy_o;
        obs_ovf = overflow_o; obs_req = mem_request_o; obs_addr = mem_address_o;
        obs_mvalid = be_v;
        m_pend = 1'b0;
        if (be_v && m_fly.size() > 0) begin
            fl = m_fly.pop_front();
            if (fl.live && !inv) begin
                m_pend = 1'b1;
                m_data = fdata(fl.addr);
            end
        end
        if (inv) foreach (m_fly[i]) m_fly[i].live = 1'b0;
        acc = req && !inv && (!e_full || e_issue);
        if (e_issue) begin
            m_fly.push_back('{e_addr, 1'b1});
            void'(m_fifo.pop_front());
        end
        if (inv) m_fifo.delete();
        if (acc) m_fifo.push_back(addr);
        if (inv) m_ovf = 1'b0;
        else if (req && e_full && !e_issue) m_ovf = 1'b1;
        if (mem_request_o) begin
            due = cyc + be_lat;
            if (due <= last_due) due = last_due + 1;
            be_q.push_back('{mem_address_o, due});
            last_due = due;
        end
        cyc++;
    endtask

    task automatic drain(input int limit, output int nvalid, output logic [31:0] lastd);
        nvalid = 0;
        lastd  = '0;
        for (int i = 0; i < limit; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1);
            if (obs_valid) begin
                nvalid++;
                lastd = obs_data;
            end
            if (!obs_busy) break;
        end
        chk("drain_idle", obs_busy, 1'b0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_valid"}, valid_o, 1'b0);
        chk({tag, "_data"}, data_o, 32'h0);
        chk({tag, "_full"}, full_o, 1'b0);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_ovf"}, overflow_o, 1'b0);
        chk({tag, "_mreq"}, mem_request_o, 1'b0);
        chk({tag, "_maddr"}, mem_address_o, 32'h0);
    endtask

    typedef struct {
        bit req; logic [31:0] addr; bit inv; bit rdy;
        bit e_mreq; bit e_valid; logic [31:0] e_vaddr; bit e_busy;
    } vec_t;

    initial begin
        vec_t        tbl[9];
        int          nv, nbefore;
        bit          seen, bad;
        logic [31:0] ld;

        rst_n_i = 1'b0; request_i = 1'b0; address_i = '0; invalidate_i = 1'b0;
        mem_ready_i = 1'b0; mem_data_i = '0; mem_valid_i = 1'b0;
        model_clear();
        #1;
        check_outputs_zero("reset");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // 4-word burst, backend latency 2
        tbl[0] = '{1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0};
        tbl[1] = '{1'b1, 32'h104, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1};
        tbl[2] = '{1'b1, 32'h108, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1};
        tbl[3] = '{1'b1, 32'h10C, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1};
        tbl[4] = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 1'b1};
        tbl[5] = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b1, 32'h104, 1'b1};
        tbl[6] = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b1, 32'h108, 1'b1};
        tbl[7] = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b1, 32'h10C, 1'b0};
        tbl[8] = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0};
        be_lat = 2;
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].req, tbl[i].addr, tbl[i].inv, tbl[i].rdy);
            chk("tbl_mreq", obs_req, tbl[i].e_mreq);
            chk("tbl_valid", obs_valid, tbl[i].e_valid);
            chk("tbl_busy", obs_busy, tbl[i].e_busy);
            if (tbl[i].e_valid) chk("tbl_data", obs_data, fdata(tbl[i].e_vaddr));
        end

        // Fill the FIFO with the backend stalled, then overflow it
        for (int i = 0; i < 8; i++) step(1'b1, 32'h300 + 32'(4*i), 1'b0, 1'b0);
        step(1'b1, 32'h400, 1'b0, 1'b0);
        chk("ovf_full_after_8", obs_full, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("ovf_set", obs_ovf, 1'b1);
        drain(60, nv, ld);
        chk("ovf_resp_count", nv, 8);
        chk("ovf_last_data", ld, fdata(32'h31C));
        chk("ovf_sticky", obs_ovf, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("ovf_cleared", obs_ovf, 1'b0);

        // Outstanding limit with a slow backend
        be_lat = 6;
        for (int i = 0; i < 6; i++) step(1'b1, 32'h800 + 32'(4*i), 1'b0, 1'b0);
        seen = 1'b0; nbefore = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1);
            if (obs_mvalid) seen = 1'b1;
            if (obs_req && !seen) nbefore++;
            if (!obs_busy) break;
        end
        chk("maxo_issue_before_resp", nbefore, 4);
        chk("maxo_idle", obs_busy, 1'b0);

        // Invalidate with 3 reads in flight and 1 queued
        be_lat = 5;
        step(1'b1, 32'h100, 1'b0, 1'b1);
        step(1'b1, 32'h104, 1'b0, 1'b1);
        step(1'b1, 32'h108, 1'b0, 1'b1);
        step(1'b1, 32'h10C, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("inv_no_issue", obs_req, 1'b0);
        step(1'b1, 32'h200, 1'b0, 1'b1);
        bad = 1'b0; nv = 0; ld = '0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1);
            if (obs_req && obs_addr == 32'h10C) bad = 1'b1;
            if (obs_valid) begin nv++; ld = obs_data; end
            if (!obs_busy) break;
        end
        chk("inv_resp_count", nv, 1);
        chk("inv_new_data", ld, fdata(32'h200));
        chk("inv_flushed_never_issued", bad, 1'b0);

        // Invalidate coincident with response, request and pending valid
        be_lat = 2;
        for (int i = 0; i < 4; i++) step(1'b1, 32'h500 + 32'(4*i), 1'b0, 1'b1);
        step(1'b1, 32'h600, 1'b1, 1'b1);
        chk("coinc_valid_masked", obs_valid, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("coinc_dropped_1", obs_valid, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("coinc_dropped_2", obs_valid, 1'b0);
        chk("coinc_idle", obs_busy, 1'b0);

        // Asynchronous reset mid-burst
        be_lat = 3;
        step(1'b1, 32'h700, 1'b0, 1'b1);
        step(1'b1, 32'h704, 1'b0, 1'b1);
        step(1'b1, 32'h708, 1'b0, 1'b1);
        @(negedge clk_i);
        #2 rst_n_i = 1'b0;
        #1;
        check_outputs_zero("midrst");
        model_clear();
        request_i = 1'b0; invalidate_i = 1'b0; mem_valid_i = 1'b0; mem_ready_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        step(1'b1, 32'h43, 1'b0, 1'b1);
        drain(40, nv, ld);
        chk("rst_resp_count", nv, 1);
        chk("rst_resp_data", ld, fdata(32'h40));

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            be_lat = $urandom_range(1, 5);
            step($urandom_range(0, 99) < 60, $urandom(), $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 75);
        end
        be_lat = 2;
        drain(100, nv, ld);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
